// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory bus between instruction fetch and data access; drops flushed fetch responses.
// Latency: bus request registered one cycle after grant; response steered back combinationally; IDLE lasts >= 1 cycle.
// Backpressure: requesters hold their request until their response; one bus transaction outstanding at a time.
module mem_port_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int STREAK_W     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  input  logic        iflush,
  output logic        iresp_valid,
  output logic [31:0] iresp_data,
  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic        dreq_write,
  input  logic [2:0]  dreq_size,
  input  logic [63:0] dreq_wdata,
  output logic        dresp_valid,
  output logic [63:0] dresp_data,
  output logic        breq_valid,
  output logic [63:0] breq_addr,
  output logic        breq_write,
  output logic [2:0]  breq_size,
  output logic [7:0]  breq_strobe,
  output logic [63:0] breq_wdata,
  input  logic        bresp_valid,
  input  logic [63:0] bresp_data
);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_I_DROP, BUSY_D, ZERO_D} state_t;

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  state_t              state;
  logic [STREAK_W-1:0] streak;
  logic                isel;      // which 32-bit half of the dword holds the instruction

  logic                grant_d;
  logic                grant_i;
  logic [2:0]          lane;
  logic [7:0]          d_strobe;
  logic [63:0]         d_wdata;
  logic                unused_ireq_bits;

  assign unused_ireq_bits = ^ireq_addr[1:0];

  // Data wins unless it has starved a waiting fetch for MAX_D_STREAK grants; a flush blocks the fetch grant.
  assign grant_d = dreq_valid && !(ireq_valid && (streak == STREAK_MAX));
  assign grant_i = !grant_d && ireq_valid && !iflush;

  assign lane = dreq_addr[2:0];

  // Byte enables and lane-aligned store data; strobe bits shifted past byte 7 fall off.
  always_comb begin
    d_strobe = 8'h00;
    d_wdata  = dreq_wdata << {lane, 3'b000};
    case (dreq_size)
      3'd1: d_strobe = 8'h01 << lane;
      3'd2: d_strobe = 8'h03 << lane;
      3'd3: d_strobe = 8'h0F << lane;
      3'd4: begin
        d_strobe = 8'hFF;
        d_wdata  = dreq_wdata;
      end
      default: d_strobe = 8'h00;
    endcase
    if (!dreq_write) d_strobe = 8'h00;
  end

  // Arbitration, streak tracking and registered bus request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      streak      <= '0;
      isel        <= 1'b0;
      breq_valid  <= 1'b0;
      breq_addr   <= '0;
      breq_write  <= 1'b0;
      breq_size   <= '0;
      breq_strobe <= '0;
      breq_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state  <= (dreq_size == 3'd0) ? ZERO_D : BUSY_D;
            streak <= !ireq_valid ? '0 :
                      (streak == STREAK_MAX) ? streak : streak + 1'b1;
            if (dreq_size != 3'd0) begin
              breq_valid  <= 1'b1;
              breq_addr   <= dreq_addr;
              breq_write  <= dreq_write;
              breq_size   <= dreq_size;
              breq_strobe <= d_strobe;
              breq_wdata  <= d_wdata;
            end
          end else if (grant_i) begin
            state       <= BUSY_I;
            streak      <= '0;
            isel        <= ireq_addr[2];
            breq_valid  <= 1'b1;
            breq_addr   <= {ireq_addr[63:3], 3'b000};
            breq_write  <= 1'b0;
            breq_size   <= 3'd3;
            breq_strobe <= 8'h00;
            breq_wdata  <= '0;
          end
        end
        BUSY_I, BUSY_I_DROP, BUSY_D: begin
          // The bus transaction always runs to completion, even when its fetch was cancelled.
          if (bresp_valid) begin
            state       <= IDLE;
            breq_valid  <= 1'b0;
            breq_addr   <= '0;
            breq_write  <= 1'b0;
            breq_size   <= '0;
            breq_strobe <= '0;
            breq_wdata  <= '0;
          end else if ((state == BUSY_I) && iflush) begin
            state <= BUSY_I_DROP;
          end
        end
        ZERO_D:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Steer the bus response to its owner; a coincident flush kills the fetch response.
  assign iresp_valid = (state == BUSY_I) && bresp_valid && !iflush;
  assign iresp_data  = isel ? bresp_data[63:32] : bresp_data[31:0];
  assign dresp_valid = ((state == BUSY_D) && bresp_valid) || (state == ZERO_D);
  assign dresp_data  = (state == BUSY_D) ? bresp_data : 64'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester, bus and monitor processes plus directed and random phases.
// Expected responses come from the request contents and a fixed bus memory function.
// Bus model inserts random latency; requesters insert random gaps and fetch flushes.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ireq_valid = 1'b0;
  logic [63:0] ireq_addr = '0;
  logic        iflush = 1'b0;
  logic        iresp_valid;
  logic [31:0] iresp_data;
  logic        dreq_valid = 1'b0;
  logic [63:0] dreq_addr = '0;
  logic        dreq_write = 1'b0;
  logic [2:0]  dreq_size = '0;
  logic [63:0] dreq_wdata = '0;
  logic        dresp_valid;
  logic [63:0] dresp_data;
  logic        breq_valid;
  logic [63:0] breq_addr;
  logic        breq_write;
  logic [2:0]  breq_size;
  logic [7:0]  breq_strobe;
  logic [63:0] breq_wdata;
  logic        bresp_valid = 1'b0;
  logic [63:0] bresp_data = '0;

  mem_port_arbiter #(.MAX_D_STREAK(4), .STREAK_W(3)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .iflush(iflush),
    .iresp_valid(iresp_valid), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_write(dreq_write),
    .dreq_size(dreq_size), .dreq_wdata(dreq_wdata),
    .dresp_valid(dresp_valid), .dresp_data(dresp_data),
    .breq_valid(breq_valid), .breq_addr(breq_addr), .breq_write(breq_write),
    .breq_size(breq_size), .breq_strobe(breq_strobe), .breq_wdata(breq_wdata),
    .bresp_valid(bresp_valid), .bresp_data(bresp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          flush_cyc;   // >0: cancel with iflush this many cycles after issue
    int          gap;
  } icmd_t;

  typedef struct {
    logic [63:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [63:0] wdata;
    int          gap;
  } dcmd_t;

  icmd_t       i_cmds[$];
  dcmd_t       d_cmds[$];
  logic [31:0] i_exp[$];
  logic [63:0] d_exp[$];
  int          grant_log[$];     // 1 = data, 0 = fetch
  logic [7:0]  strobe_log[$];
  logic [63:0] wdata_log[$];
  logic [63:0] addr_log[$];

  int    checks = 0;
  int    passes = 0;
  int    i_resp_cnt = 0;
  int    d_resp_cnt = 0;
  int    bus_lat = 0;            // <0 selects random latency
  logic  i_busy = 1'b0;
  logic  d_busy = 1'b0;
  logic  bus_active = 1'b0;
  logic [63:0] i_last_addr = '0;
  dcmd_t d_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Contents of bus memory at a given address.
  function automatic logic [63:0] bus_word(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h11223344_55667788;
    return {a[31:0] ^ 32'h5A5A_C3C3, a[63:32] ^ ~a[31:0]};
  endfunction

  // Byte enables: one bit per byte the store covers, starting at the byte offset, limited to the dword.
  function automatic logic [7:0] ref_strobe(input logic write, input logic [2:0] size, input logic [63:0] addr);
    logic [7:0] s;
    int n;
    int a;
    s = 8'h00;
    a = int'(addr[2:0]);
    if (!write) return 8'h00;
    case (size)
      3'd1: n = 1;
      3'd2: n = 2;
      3'd3: n = 4;
      3'd4: return 8'hFF;
      default: return 8'h00;
    endcase
    for (int i = 0; i < n; i++)
      if (a + i < 8) s[a + i] = 1'b1;
    return s;
  endfunction

  // Store data placed so its byte 0 lands on the addressed byte lane.
  function automatic logic [63:0] ref_wdata(input logic [2:0] size, input logic [63:0] addr, input logic [63:0] wd);
    logic [63:0] o;
    int a;
    o = '0;
    a = int'(addr[2:0]);
    if (size == 3'd4) return wd;
    for (int j = 0; j < 8; j++)
      if (j >= a) o[8*j +: 8] = wd[8*(j-a) +: 8];
    return o;
  endfunction

  // Fetch requester: holds a request until its response, or cancels it with a one-cycle flush.
  initial begin : i_requester
    int seen;
    int cnt;
    int gap;
    icmd_t cur;
    logic [63:0] w;
    seen = 0; cnt = 0; gap = 0;
    forever begin
      @(posedge clk); #1;
      iflush = 1'b0;
      if (i_busy) begin
        if (i_resp_cnt != seen) begin
          seen = i_resp_cnt;
          i_busy = 1'b0;
          ireq_valid = 1'b0;
        end else begin
          cnt++;
          if (cur.flush_cyc > 0 && cnt == cur.flush_cyc) begin
            iflush = 1'b1;
            ireq_valid = 1'b0;
            i_busy = 1'b0;
            i_exp.delete();
          end
        end
      end
      if (!i_busy && !iflush && i_cmds.size() > 0) begin
        if (gap < i_cmds[0].gap) gap++;
        else begin
          gap = 0;
          cur = i_cmds.pop_front();
          ireq_addr = cur.addr;
          ireq_valid = 1'b1;
          i_busy = 1'b1;
          cnt = 0;
          seen = i_resp_cnt;
          i_last_addr = cur.addr;
          w = bus_word({cur.addr[63:3], 3'b000});
          i_exp.push_back(cur.addr[2] ? w[63:32] : w[31:0]);
        end
      end
    end
  end

  // Data requester: holds all fields until its response; an async reset abandons the request.
  initial begin : d_requester
    int seen;
    int gap;
    dcmd_t cur;
    seen = 0; gap = 0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        d_busy = 1'b0;
        dreq_valid = 1'b0;
        seen = d_resp_cnt;
        continue;
      end
      if (d_busy && d_resp_cnt != seen) begin
        seen = d_resp_cnt;
        d_busy = 1'b0;
        dreq_valid = 1'b0;
      end
      if (!d_busy && d_cmds.size() > 0) begin
        if (gap < d_cmds[0].gap) gap++;
        else begin
          gap = 0;
          cur = d_cmds.pop_front();
          dreq_addr = cur.addr;
          dreq_write = cur.write;
          dreq_size = cur.size;
          dreq_wdata = cur.wdata;
          dreq_valid = 1'b1;
          d_busy = 1'b1;
          seen = d_resp_cnt;
          d_last = cur;
          d_exp.push_back(cur.size == 3'd0 ? 64'd0 : bus_word(cur.addr));
        end
      end
    end
  end

  // Bus model: checks each new request against whichever requester it should belong to, then completes it.
  initial begin : bus_model
    int cnt;
    logic drop_chk;
    logic [63:0] a_hold;
    logic is_i;
    logic is_d;
    cnt = 0; drop_chk = 1'b0; a_hold = '0;
    forever begin
      @(posedge clk); #1;
      bresp_valid = 1'b0;
      if (reset) begin
        bus_active = 1'b0;
        drop_chk = 1'b0;
        continue;
      end
      if (drop_chk) begin
        check("breq_drop_after_resp", breq_valid, 1'b0);
        drop_chk = 1'b0;
      end else if (bus_active) begin
        check("breq_held_stable", breq_valid && (breq_addr == a_hold), 1'b1);
        if (cnt == 0) begin
          bresp_valid = 1'b1;
          bresp_data = bus_word(breq_addr);
          bus_active = 1'b0;
          drop_chk = 1'b1;
        end else cnt--;
      end else if (breq_valid) begin
        is_i = !breq_write && breq_size == 3'd3 && breq_strobe == 8'h00 &&
               breq_addr == {i_last_addr[63:3], 3'b000};
        is_d = d_last.size != 3'd0 && breq_addr == d_last.addr && breq_write == d_last.write &&
               breq_size == d_last.size &&
               breq_strobe == ref_strobe(d_last.write, d_last.size, d_last.addr) &&
               (!d_last.write || breq_wdata == ref_wdata(d_last.size, d_last.addr, d_last.wdata));
        check("breq_fields", is_i || is_d, 1'b1);
        grant_log.push_back(is_d ? 1 : 0);
        strobe_log.push_back(breq_strobe);
        wdata_log.push_back(breq_wdata);
        addr_log.push_back(breq_addr);
        bus_active = 1'b1;
        a_hold = breq_addr;
        cnt = (bus_lat >= 0) ? bus_lat : int'($urandom_range(0, 3));
      end
    end
  end

  // Monitor: pops the scoreboard whenever a response is presented.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (iresp_valid || dresp_valid)
          check("resp_exclusive", iresp_valid && dresp_valid, 1'b0);
        if (iresp_valid) begin
          check("iresp_expected", i_exp.size() > 0, 1'b1);
          if (i_exp.size() > 0) check("iresp_data", iresp_data, i_exp.pop_front());
          i_resp_cnt++;
        end
        if (dresp_valid) begin
          check("dresp_expected", d_exp.size() > 0, 1'b1);
          if (d_exp.size() > 0) check("dresp_data", dresp_data, d_exp.pop_front());
          d_resp_cnt++;
        end
      end
    end
  end

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((i_cmds.size() != 0 || d_cmds.size() != 0 || i_busy || d_busy || bus_active) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain_done", n < budget, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_logs();
    grant_log.delete();
    strobe_log.delete();
    wdata_log.delete();
    addr_log.delete();
  endtask

  initial begin : main
    int r0;
    int n;
    icmd_t ic;
    dcmd_t dc;
    d_last = '{64'd0, 1'b0, 3'd0, 64'd0, 0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_breq_valid", breq_valid, 1'b0);
    check("rst_breq_addr", breq_addr, 64'd0);
    check("rst_breq_strobe", breq_strobe, 8'd0);
    check("rst_iresp_valid", iresp_valid, 1'b0);
    check("rst_dresp_valid", dresp_valid, 1'b0);
    reset = 1'b0;

    // Fetch only
    bus_lat = 1;
    clear_logs();
    r0 = i_resp_cnt;
    i_cmds.push_back('{64'h8000_0004, 0, 0});
    drain(200);
    check("fetch_resp_count", i_resp_cnt - r0, 1);
    check("fetch_req_count", grant_log.size(), 1);
    if (grant_log.size() > 0) begin
      check("fetch_breq_addr", addr_log[0], 64'h8000_0000);
      check("fetch_breq_strobe", strobe_log[0], 8'h00);
    end

    // Byte store while a fetch waits
    bus_lat = 1;
    clear_logs();
    r0 = i_resp_cnt;
    d_cmds.push_back('{64'h1003, 1'b1, 3'd1, 64'hAB, 0});
    i_cmds.push_back('{64'h2000, 0, 0});
    drain(200);
    check("bs_req_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("bs_first_owner_data", grant_log[0], 1);
      check("bs_strobe", strobe_log[0], 8'h08);
      check("bs_wdata", wdata_log[0], 64'hAB00_0000);
      check("bs_second_owner_fetch", grant_log[1], 0);
    end
    check("bs_fetch_resp_count", i_resp_cnt - r0, 1);

    // Contention: both requesters always busy
    bus_lat = 0;
    clear_logs();
    for (int k = 0; k < 10; k++) begin
      dc = '{64'h100 + 64'(16 * k) + 64'd1, 1'b1, 3'd1, 64'(k + 1), 0};
      d_cmds.push_back(dc);
    end
    for (int k = 0; k < 3; k++) begin
      ic = '{64'h3000 + 64'(8 * k), 0, 0};
      i_cmds.push_back(ic);
    end
    drain(500);
    check("cont_req_count", grant_log.size(), 13);
    if (grant_log.size() >= 10)
      for (int k = 0; k < 10; k++)
        check($sformatf("cont_grant_%0d", k), grant_log[k], (k % 5 == 4) ? 0 : 1);

    // Flush one cycle before and coincident with the bus response
    bus_lat = 1;
    clear_logs();
    r0 = i_resp_cnt;
    i_cmds.push_back('{64'h4000, 2, 0});
    drain(200);
    d_cmds.push_back('{64'h5008, 1'b0, 3'd3, 64'd0, 0});
    drain(200);
    i_cmds.push_back('{64'h6004, 3, 0});
    drain(200);
    check("flush_no_iresp", i_resp_cnt - r0, 0);
    check("flush_bus_completes", grant_log.size(), 3);

    // Zero-size data access
    clear_logs();
    r0 = d_resp_cnt;
    d_cmds.push_back('{64'h7000, 1'b1, 3'd0, 64'h55, 0});
    drain(200);
    check("zero_no_bus", grant_log.size(), 0);
    check("zero_dresp_count", d_resp_cnt - r0, 1);

    // Async reset in the middle of a data transaction
    bus_lat = 6;
    clear_logs();
    d_cmds.push_back('{64'h9000, 1'b0, 3'd3, 64'd0, 0});
    n = 0;
    while (!bus_active && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    check("arst_reached_busy", bus_active, 1'b1);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check("arst_breq_valid", breq_valid, 1'b0);
    check("arst_breq_addr", breq_addr, 64'd0);
    check("arst_dresp_valid", dresp_valid, 1'b0);
    check("arst_iresp_valid", iresp_valid, 1'b0);
    d_exp.delete();
    i_cmds.push_back('{64'hA004, 0, 0});
    bus_lat = 2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("arst_first_grant_valid", breq_valid, 1'b1);
    check("arst_first_grant_addr", breq_addr, 64'hA000);
    drain(200);

    // Randomized traffic
    bus_lat = -1;
    for (int k = 0; k < 150; k++) begin
      ic.addr = {$urandom(), $urandom()};
      ic.flush_cyc = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 5)) : 0;
      ic.gap = int'($urandom_range(0, 3));
      i_cmds.push_back(ic);
      dc.addr = {$urandom(), $urandom()};
      dc.write = 1'($urandom_range(0, 1));
      dc.size = 3'($urandom_range(0, 4));
      dc.wdata = {$urandom(), $urandom()};
      dc.gap = int'($urandom_range(0, 3));
      d_cmds.push_back(dc);
    end
    drain(20000);

    check("end_i_exp_empty", i_exp.size(), 0);
    check("end_d_exp_empty", d_exp.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the pipeline's single 64-bit memory bus between two requesters: instruction fetch (IF stage) and data access (MEM stage: load/store per `ctl.MemRead`, `ctl.MemWrite`, `ctl.MemSize`).
- Grants one requester at a time and registers its request onto the bus.
- Forms the byte strobe and write-data lane alignment, then steers the bus response back to the owner.
- Drops fetch responses cancelled by a branch flush.

Parameters:
- MAX_D_STREAK, 4, number of consecutive data grants, taken while a fetch is pending, before fetch is forced to win one arbitration.
- STREAK_W, 3, counter width; must satisfy 2^STREAK_W > MAX_D_STREAK.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ireq_valid  in  1  fetch request; held with ireq_addr stable until iresp_valid.
- ireq_addr  in  64  fetch PC.
- iflush  in  1  cancels the pending or in-flight fetch (branch/jal/jalr redirect).
- iresp_valid  out  1  fetch data valid for one cycle.
- iresp_data  out  32  raw instruction.
- dreq_valid  in  1  data request; held with all fields stable until dresp_valid.
- dreq_addr  in  64  byte address.
- dreq_write  in  1  1 = store, 0 = load.
- dreq_size  in  3  MemSizeType encoding: 0 = zero, 1 = 8 bits, 2 = 16 bits, 3 = 32 bits, 4 = 64 bits.
- dreq_wdata  in  64  store data, right-aligned.
- dresp_valid  out  1  data access complete for one cycle.
- dresp_data  out  64  raw bus dword, unshifted; MEM/WB extracts and extends.
- breq_valid  out  1  bus request; held stable until bresp_valid.
- breq_addr  out  64  bus address.
- breq_write  out  1  bus write.
- breq_size  out  3  MemSizeType encoding.
- breq_strobe  out  8  byte enables; 0 for reads.
- breq_wdata  out  64  lane-aligned write data.
- bresp_valid  in  1  bus completion, one cycle.
- bresp_data  in  64  bus read data.

Behaviour:
- States are IDLE, BUSY_I, BUSY_I_DROP, BUSY_D and ZERO_D.
- Reset (async, at any time including mid-transaction):
  - state = IDLE, streak = 0.
  - All breq_* = 0; iresp_valid = dresp_valid = 0.
  - An in-flight bus transaction is abandoned; the bus is reset by the same signal.
- IDLE arbitration, evaluated each cycle:
  - dreq_valid && !(ireq_valid && streak == MAX_D_STREAK) → grant data. Go to BUSY_D, or to ZERO_D if dreq_size == 0.
  - Else ireq_valid && !iflush → grant fetch → BUSY_I.
  - Else stay in IDLE.
- Streak counter:
  - Data grant with ireq_valid high → streak + 1, saturating at MAX_D_STREAK.
  - Any fetch grant, or data grant with ireq_valid low → streak = 0.
- Request registration: breq_* are loaded on the grant edge, so breq_valid rises the cycle after the request is sampled. Fields are held until bresp_valid; breq_valid drops on the edge after bresp_valid.
- Fetch request fields:
  - breq_addr = {ireq_addr[63:3], 3'b000}.
  - breq_write = 0, breq_size = 3 (32 bits), breq_strobe = 0.
  - The value of ireq_addr[2] is captured at grant.
- Data request fields:
  - breq_addr = dreq_addr, breq_write = dreq_write, breq_size = dreq_size.
  - Store strobe by size, with a = addr[2:0] and results truncated to 8 bits: 8-bit = 0x01<<a; 16-bit = 0x03<<a; 32-bit = 0x0F<<a; 64-bit = 0xFF.
  - Load strobe = 0.
  - breq_wdata = dreq_wdata << (8*a) for 8/16/32-bit sizes; unshifted for 64-bit.
  - Misalignment is not checked; out-of-range strobe bits are truncated.
- BUSY_I:
  - bresp_valid → iresp_valid = 1 in the same cycle (combinational).
  - iresp_data = captured addr[2] ? bresp_data[63:32] : bresp_data[31:0].
  - Next state IDLE.
  - iflush while bresp_valid is low → BUSY_I_DROP.
  - iflush in the same cycle as bresp_valid → the response is suppressed (iresp_valid = 0); next state IDLE.
- BUSY_I_DROP: wait for bresp_valid, iresp_valid stays 0, then → IDLE. Bus transactions are never aborted.
- BUSY_D: bresp_valid → dresp_valid = 1 and dresp_data = bresp_data in the same cycle; next state IDLE. iflush has no effect in this state.
- ZERO_D: dresp_valid = 1 and dresp_data = 0 for one cycle with no bus transaction; next state IDLE.
- IDLE always lasts at least one cycle between transactions, so a requester sees its response, updates its request, and the new value is sampled in IDLE.
- iflush in IDLE suppresses the fetch grant for that cycle only.
- iresp_valid and dresp_valid are never high in the same cycle. At most one bus transaction is outstanding.

Test Plan:
- Fetch only: ireq_addr = 0x80000004; bus returns 0x11223344_55667788 two cycles after breq_valid → breq_addr = 0x80000000, breq_strobe = 0, iresp_valid one cycle, iresp_data = 0x11223344; state back to IDLE.
- Byte store: addr = 0x1003, size = 1, wdata = 0xAB, write = 1 → breq_strobe = 0x08, breq_wdata = 0xAB000000; dresp_valid on bresp_valid; ireq_valid held meanwhile with no iresp.
- Contention with MAX_D_STREAK = 4: dreq_valid and ireq_valid held continuously → grant order D, D, D, D, I, D...; streak is 0 after the fetch grant.
- Flush in flight: fetch granted, iflush pulsed one cycle before bresp_valid → no iresp_valid, next IDLE grants a pending dreq normally. Repeat with iflush coincident with bresp_valid → iresp_valid = 0.
- Zero-size data request: dreq_size = 0 → dresp_valid one cycle after grant, dresp_data = 0, breq_valid never rises.
- Async reset asserted in BUSY_D between clock edges → breq_valid and all outputs 0 immediately, state IDLE; after release, a pending fetch is granted on the first edge.
